// File: rtl/frame_slot_tracker.sv
// Rebuilds neuron-slot timing (slot/neuron/sub-slot, frame lock, period check) from a sampled sim clock.
// Latency: slot_strobe rises SYNC_STAGES+1 rawclk edges after sim_clk_in goes high; all outputs registered.
// Backpressure: none; free-running observer, consumers must take each single-cycle strobe when it occurs.
//
// Ports:
//   rawclk, reset              system clock (posedge) and asynchronous active-high reset
//   sim_clk_in, frame_pulse_in divided sim clock and frame marker, both sampled as data
//   half_cnt                   divider setting; nominal sim-clock period is 2*(half_cnt+1) rawclk
//   clear_err                  zeroes err_cnt and period_err (a same-cycle new error wins)
//   slot_strobe                one pulse per synchronized sim_clk_in rising edge
//   slot_cnt/neuron_index/sub_slot  reconstructed slot position, updated with the strobe
//   frame_start, locked, frame_err  frame alignment status
//   err_cnt, period_err        saturating alignment error count, sticky period/timeout flag
module frame_slot_tracker #(
  parameter int NN          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 2,
  parameter int PERIOD_TOL  = 1
) (
  input  logic          rawclk,
  input  logic          reset,
  input  logic          sim_clk_in,
  input  logic          frame_pulse_in,
  input  logic [31:0]   half_cnt,
  input  logic          clear_err,
  output logic          slot_strobe,
  output logic [NN+2:0] slot_cnt,
  output logic [NN:0]   neuron_index,
  output logic [1:0]    sub_slot,
  output logic          frame_start,
  output logic          locked,
  output logic          frame_err,
  output logic [15:0]   err_cnt,
  output logic          period_err
);

  localparam int SW = NN + 3;
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] fp_sync_q, fp_sync_d;
  logic                   clk_dly_q, clk_dly_d;
  logic [SW-1:0]          slot_cnt_q, slot_cnt_d, slot_inc;
  logic [GW-1:0]          good_q, good_d, good_inc;
  logic [31:0]            per_cnt_q, per_cnt_d;
  logic                   armed_q, armed_d;
  logic                   strobe_q, strobe_d;
  logic                   frame_start_q, frame_start_d;
  logic                   locked_q, locked_d;
  logic                   frame_err_q, frame_err_d;
  logic                   period_err_q, period_err_d;
  logic [15:0]            err_cnt_q, err_cnt_d;

  logic        rise, pulse, expected, mismatch, per_bad, timeout;
  logic [33:0] per_exp, per_meas, per_diff;
  logic [34:0] tmo_lim;

  // Synchronizers and period measurement
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], sim_clk_in};
    fp_sync_d  = {fp_sync_q[SYNC_STAGES-2:0], frame_pulse_in};
    clk_dly_d  = clk_sync_q[SYNC_STAGES-1];
    rise       = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
    // Both inputs travel through equal-length chains, so the marker lines up with the rise.
    pulse      = fp_sync_q[SYNC_STAGES-1];

    per_exp  = ({2'b00, half_cnt} + 34'd1) << 1;
    per_meas = {2'b00, per_cnt_q};
    per_diff = (per_meas >= per_exp) ? (per_meas - per_exp) : (per_exp - per_meas);
    per_bad  = per_diff > 34'(PERIOD_TOL);

    // 4*(half_cnt+1) needs one bit more than the period compare when half_cnt is all ones.
    tmo_lim  = ({3'b000, half_cnt} + 35'd1) << 2;
    // Armed only after a rise, so a stopped clock flags once and clear_err can then clear it.
    timeout  = armed_q & ~rise & ({3'b000, per_cnt_q} > tmo_lim);

    per_cnt_d = per_cnt_q;
    if (rise) begin
      per_cnt_d = 32'd1;
    end else if (per_cnt_q != 32'hFFFF_FFFF) begin
      per_cnt_d = per_cnt_q + 32'd1;
    end

    armed_d = armed_q;
    if (rise) begin
      armed_d = 1'b1;
    end else if (timeout) begin
      armed_d = 1'b0;
    end
  end

  // Frame FSM, slot counter and error bookkeeping
  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q;
    good_d        = good_q;
    strobe_d      = rise;
    frame_start_d = 1'b0;
    frame_err_d   = 1'b0;
    slot_inc      = slot_cnt_q + SW'(1);
    good_inc      = good_q + GW'(1);
    expected      = (slot_inc == '0);
    mismatch      = (pulse != expected);

    if (rise) begin
      case (state_q)
        HUNT: begin
          if (pulse) begin
            slot_cnt_d = '0;
            good_d     = GW'(1);
            state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          slot_cnt_d = slot_inc;
          if (expected && pulse) begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_CNT)) state_d = LOCKED;
          end else if (mismatch) begin
            // A marker in the wrong slot restarts verification from it; a missing one drops to HUNT.
            if (pulse) begin
              slot_cnt_d = '0;
              good_d     = GW'(1);
              state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            end else begin
              good_d  = '0;
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          slot_cnt_d    = slot_inc;
          frame_start_d = expected & ~mismatch;
          if (mismatch) begin
            frame_err_d = 1'b1;
            if (pulse) begin
              slot_cnt_d = '0;
              good_d     = GW'(1);
              state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            end else begin
              good_d  = '0;
              state_d = HUNT;
            end
          end
        end
        default: begin
          state_d = HUNT;
          good_d  = '0;
        end
      endcase
    end

    if (timeout) begin
      state_d = HUNT;
      good_d  = '0;
    end

    locked_d = (state_d == LOCKED);

    err_cnt_d = clear_err ? 16'd0 : err_cnt_q;
    if (frame_err_d) begin
      if (clear_err)                 err_cnt_d = 16'd1;
      else if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    period_err_d = clear_err ? 1'b0 : period_err_q;
    if ((rise && armed_q && per_bad) || timeout) period_err_d = 1'b1;
  end

  always_ff @(posedge rawclk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      clk_sync_q    <= '0;
      fp_sync_q     <= '0;
      clk_dly_q     <= 1'b0;
      slot_cnt_q    <= '0;
      good_q        <= '0;
      per_cnt_q     <= '0;
      armed_q       <= 1'b0;
      strobe_q      <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      period_err_q  <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      fp_sync_q     <= fp_sync_d;
      clk_dly_q     <= clk_dly_d;
      slot_cnt_q    <= slot_cnt_d;
      good_q        <= good_d;
      per_cnt_q     <= per_cnt_d;
      armed_q       <= armed_d;
      strobe_q      <= strobe_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      frame_err_q   <= frame_err_d;
      period_err_q  <= period_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign slot_strobe  = strobe_q;
  assign slot_cnt     = slot_cnt_q;
  assign neuron_index = slot_cnt_q[NN+2:2];
  assign sub_slot     = slot_cnt_q[1:0];
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign frame_err    = frame_err_q;
  assign err_cnt      = err_cnt_q;
  assign period_err   = period_err_q;

endmodule

// File: tb/tb_frame_slot_tracker.sv
// Directed bench for frame_slot_tracker with NN=1 (16-slot frame) and half_cnt=3 (period 8).
module tb_frame_slot_tracker;

  logic        rawclk = 1'b0;
  logic        reset = 1'b1;
  logic        sim_clk_in = 1'b0;
  logic        frame_pulse_in = 1'b0;
  logic [31:0] half_cnt = 32'd3;
  logic        clear_err = 1'b0;
  logic        slot_strobe;
  logic [3:0]  slot_cnt;
  logic [1:0]  neuron_index;
  logic [1:0]  sub_slot;
  logic        frame_start;
  logic        locked;
  logic        frame_err;
  logic [15:0] err_cnt;
  logic        period_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fs = -1;
  int fs_gap = 0;
  int n_ferr = 0;

  // Outputs captured in the cycle the strobe of the current sim-clock edge is due
  logic        c_strobe, c_fs, c_lock, c_ferr, c_perr;
  logic [3:0]  c_slot;
  logic [1:0]  c_ni, c_sub;
  logic [15:0] c_err;

  frame_slot_tracker #(.NN(1), .SYNC_STAGES(2), .LOCK_CNT(2), .PERIOD_TOL(1)) dut (
    .rawclk(rawclk), .reset(reset), .sim_clk_in(sim_clk_in), .frame_pulse_in(frame_pulse_in),
    .half_cnt(half_cnt), .clear_err(clear_err), .slot_strobe(slot_strobe), .slot_cnt(slot_cnt),
    .neuron_index(neuron_index), .sub_slot(sub_slot), .frame_start(frame_start), .locked(locked),
    .frame_err(frame_err), .err_cnt(err_cnt), .period_err(period_err)
  );

  always #5 rawclk = ~rawclk;

  task automatic tick();
    @(posedge rawclk);
    #1;
    cyc++;
    if (frame_start) begin
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
    end
    if (frame_err) n_ferr++;
  endtask

  // One sim-clock period: hi rawclk high then lo low; marker held through the high phase.
  // The strobe for this edge is expected after the 3rd rawclk edge of the high phase.
  task automatic sim_cycle(input int hi, input int lo, input logic p);
    sim_clk_in = 1'b1;
    frame_pulse_in = p;
    tick(); tick(); tick();
    c_strobe = slot_strobe; c_slot = slot_cnt; c_ni = neuron_index; c_sub = sub_slot;
    c_fs = frame_start; c_lock = locked; c_ferr = frame_err; c_err = err_cnt; c_perr = period_err;
    for (int i = 3; i < hi; i++) tick();
    sim_clk_in = 1'b0;
    frame_pulse_in = 1'b0;
    for (int i = 0; i < lo; i++) tick();
  endtask

  task automatic sclk(input logic p);
    sim_cycle(4, 4, p);
  endtask

  task automatic do_reset();
    reset = 1'b1; sim_clk_in = 1'b0; frame_pulse_in = 1'b0; clear_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic clear_tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({slot_strobe, slot_cnt, neuron_index, sub_slot, frame_start, locked, frame_err, err_cnt, period_err} !== '0)
      begin errors++; $display("FAIL reset_state: outputs=%h required 0", {slot_strobe, slot_cnt, frame_start, locked, frame_err, err_cnt, period_err}); end
    reset = 1'b0;
    tick();
    sclk(1'b1);
    repeat (5) sclk(1'b0);
    checks++;
    if (c_slot !== 4'd5) begin errors++; $display("FAIL pre_reset_slot: slot_cnt=%0d required 5", c_slot); end
    // Assert reset asynchronously while a rise is already in the synchronizer.
    sim_clk_in = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({slot_strobe, slot_cnt, frame_start, locked, frame_err, err_cnt, period_err} !== '0)
      begin errors++; $display("FAIL reset_async: outputs=%h required 0", {slot_strobe, slot_cnt, frame_start, locked, frame_err, err_cnt, period_err}); end
    sim_clk_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (slot_strobe !== 1'b0) begin errors++; $display("FAIL post_reset_idle: slot_strobe=%b required 0", slot_strobe); end
    end
    sim_clk_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (slot_strobe !== (i == 3)) begin errors++; $display("FAIL strobe_latency: edge %0d slot_strobe=%b required %b", i, slot_strobe, (i == 3)); end
    end
    checks++;
    if (slot_cnt !== 4'd0 || locked !== 1'b0) begin errors++; $display("FAIL hunt_hold: slot_cnt=%0d locked=%b required 0 0", slot_cnt, locked); end
    sim_clk_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_clean_lock();
    do_reset();
    sclk(1'b1);
    checks++;
    if (c_strobe !== 1'b1 || c_slot !== 4'd0 || c_lock !== 1'b0)
      begin errors++; $display("FAIL first_pulse: strobe=%b slot=%0d locked=%b required 1 0 0", c_strobe, c_slot, c_lock); end
    for (int k = 1; k < 16; k++) begin
      sclk(1'b0);
      checks++;
      if (c_ni !== 2'(k >> 2) || c_sub !== 2'(k & 3))
        begin errors++; $display("FAIL slot_fields: slot %0d neuron_index=%0d sub_slot=%0d required %0d %0d", k, c_ni, c_sub, k >> 2, k & 3); end
    end
    sclk(1'b1);
    checks++;
    if (c_lock !== 1'b1 || c_slot !== 4'd0 || c_fs !== 1'b0)
      begin errors++; $display("FAIL lock_second_pulse: locked=%b slot=%0d frame_start=%b required 1 0 0", c_lock, c_slot, c_fs); end
    repeat (15) sclk(1'b0);
    sclk(1'b1);
    checks++;
    if (c_fs !== 1'b1) begin errors++; $display("FAIL frame_start_first: frame_start=%b required 1", c_fs); end
    repeat (15) sclk(1'b0);
    sclk(1'b1);
    checks++;
    if (c_fs !== 1'b1 || fs_gap != 128) begin errors++; $display("FAIL frame_start_period: frame_start=%b gap=%0d required 1 128", c_fs, fs_gap); end
    checks++;
    if (c_err !== 16'd0 || c_perr !== 1'b0 || n_ferr != 0)
      begin errors++; $display("FAIL clean_errors: err_cnt=%0d period_err=%b frame_errs=%0d required 0 0 0", c_err, c_perr, n_ferr); end
  endtask

  task automatic test_pulse_moved();
    repeat (4) sclk(1'b0);
    sclk(1'b1);
    checks++;
    if (c_ferr !== 1'b1 || c_err !== 16'd1 || c_lock !== 1'b0 || c_slot !== 4'd0)
      begin errors++; $display("FAIL moved_pulse: frame_err=%b err_cnt=%0d locked=%b slot=%0d required 1 1 0 0", c_ferr, c_err, c_lock, c_slot); end
    repeat (15) sclk(1'b0);
    sclk(1'b1);
    checks++;
    if (c_lock !== 1'b1 || c_ferr !== 1'b0 || c_err !== 16'd1)
      begin errors++; $display("FAIL relock: locked=%b frame_err=%b err_cnt=%0d required 1 0 1", c_lock, c_ferr, c_err); end
  endtask

  task automatic test_pulse_dropped();
    clear_tick();
    checks++;
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL clear_err_cnt: err_cnt=%0d required 0", err_cnt); end
    repeat (15) sclk(1'b0);
    sclk(1'b0);
    checks++;
    if (c_ferr !== 1'b1 || c_err !== 16'd1 || c_lock !== 1'b0 || c_slot !== 4'd0)
      begin errors++; $display("FAIL dropped_pulse: frame_err=%b err_cnt=%0d locked=%b slot=%0d required 1 1 0 0", c_ferr, c_err, c_lock, c_slot); end
    for (int i = 0; i < 3; i++) begin
      sclk(1'b0);
      checks++;
      if (c_slot !== 4'd0 || c_lock !== 1'b0) begin errors++; $display("FAIL hunt_no_pulse: slot=%0d locked=%b required 0 0", c_slot, c_lock); end
    end
    sclk(1'b1);
    sclk(1'b0);
    checks++;
    if (c_slot !== 4'd1 || c_lock !== 1'b0) begin errors++; $display("FAIL reacquire: slot=%0d locked=%b required 1 0", c_slot, c_lock); end
  endtask

  task automatic test_period();
    do_reset();
    sim_cycle(5, 5, 1'b0);
    checks++;
    if (c_perr !== 1'b0) begin errors++; $display("FAIL period_first_rise: period_err=%b required 0", c_perr); end
    sim_cycle(5, 5, 1'b0);
    checks++;
    if (c_perr !== 1'b1) begin errors++; $display("FAIL period_10: period_err=%b required 1", c_perr); end
    sim_cycle(5, 3, 1'b0);
    clear_tick();
    checks++;
    if (period_err !== 1'b0) begin errors++; $display("FAIL period_clear: period_err=%b required 0", period_err); end
    sim_cycle(5, 4, 1'b0);
    checks++;
    if (c_perr !== 1'b0) begin errors++; $display("FAIL period_9a: period_err=%b required 0", c_perr); end
    sim_cycle(5, 3, 1'b0);
    clear_tick();
    checks++;
    if (period_err !== 1'b0 || err_cnt !== 16'd0) begin errors++; $display("FAIL clear_idle: period_err=%b err_cnt=%0d required 0 0", period_err, err_cnt); end
    sim_cycle(5, 4, 1'b0);
    checks++;
    if (c_perr !== 1'b0) begin errors++; $display("FAIL period_9b: period_err=%b required 0", c_perr); end
    sim_cycle(3, 3, 1'b0);
    sim_cycle(3, 3, 1'b0);
    checks++;
    if (c_perr !== 1'b1) begin errors++; $display("FAIL period_6: period_err=%b required 1", c_perr); end
  endtask

  task automatic test_saturate_timeout();
    do_reset();
    sclk(1'b1);
    repeat (15) sclk(1'b0);
    sclk(1'b1);
    checks++;
    if (c_lock !== 1'b1) begin errors++; $display("FAIL sat_lock: locked=%b required 1", c_lock); end
    force dut.err_cnt_q = 16'hFFFF;
    tick();
    release dut.err_cnt_q;
    repeat (2) sclk(1'b0);
    sclk(1'b1);
    checks++;
    if (c_ferr !== 1'b1 || c_err !== 16'hFFFF) begin errors++; $display("FAIL err_saturate: frame_err=%b err_cnt=%h required 1 ffff", c_ferr, c_err); end
    repeat (15) sclk(1'b0);
    sclk(1'b1);
    checks++;
    if (c_lock !== 1'b1) begin errors++; $display("FAIL timeout_prelock: locked=%b required 1", c_lock); end
    sim_clk_in = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (slot_strobe !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL last_rise: strobe=%b locked=%b required 1 1", slot_strobe, locked); end
    sim_clk_in = 1'b0;
    repeat (16) tick();
    checks++;
    if (period_err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL timeout_early: period_err=%b locked=%b required 0 1", period_err, locked); end
    tick();
    checks++;
    if (period_err !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL timeout: period_err=%b locked=%b required 1 0", period_err, locked); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_pulse_moved();
    test_pulse_dropped();
    test_period();
    test_saturate_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
